// File: rtl/pixel_feeder_pkg.sv
// Shared types and constants for the pixel feeder: FSM state encoding and frame geometry.
package pixel_feeder_pkg;

  localparam int unsigned PF_PIXELS = 784;
  localparam int unsigned PF_ADDR_W = 16;
  localparam int unsigned PF_CNT_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    READY,
    SWEEP,
    DRAIN,
    DONE
  } pf_state_t;

endpackage

// File: rtl/pixel_feeder_if.sv
// Pixel source stream plus image-buffer store/read bus; master is the feeder, slave the far side.
interface pixel_feeder_if #(
  parameter int unsigned PIX_W = 16
);
  import pixel_feeder_pkg::*;

  logic                    src_valid;
  logic signed [PIX_W-1:0] src_pixel;
  logic                    src_ready;

  logic                    store;
  logic signed [PIX_W-1:0] image_pixel;
  logic                    store_finish;

  logic [PF_ADDR_W-1:0]    address;
  logic                    start;
  logic                    ready_in;
  logic                    feat_valid;

  modport master (
    input  src_valid, src_pixel, store_finish, ready_in,
    output src_ready, store, image_pixel, address, start, feat_valid
  );

  modport slave (
    output src_valid, src_pixel, store_finish, ready_in,
    input  src_ready, store, image_pixel, address, start, feat_valid
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered full/empty flags; pushes at full and pops at empty are ignored.
module pixel_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= (wptr_d[AddrW] != rptr_d[AddrW]) &&
                 (wptr_d[AddrW-1:0] == rptr_d[AddrW-1:0]);
      empty_q <= (wptr_d == rptr_d);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AddrW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pixel_feeder.sv
// Buffers a pixel stream, stores one frame into the image buffer, then sweeps its read address.
// Optional store_finish timeout with sticky error: define PIXEL_FEEDER_TIMEOUT_EN.
module pixel_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int unsigned PIXELS      = PF_PIXELS,
  parameter int unsigned PIX_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           run,
  pixel_feeder_if.master bus,
  output logic           busy,
  output logic           frame_done,
  output logic           error
);

  pf_state_t             state_q, state_d;
  logic [PF_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PF_ADDR_W-1:0]  addr_q, addr_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic                  store_q, store_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [PIX_W-1:0]      fifo_rdata;
  logic                  timeout;

  pixel_fifo #(
    .Width (PIX_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (bus.src_valid && !fifo_full),
    .wdata   (bus.src_pixel),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.src_ready = !fifo_full;
  assign fifo_pop      = (state_q == LOAD) && !fifo_empty;

`ifdef PIXEL_FEEDER_TIMEOUT_EN
  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  logic [AckW-1:0] ack_cnt_q;
  logic            error_q;

  assign timeout = (state_q == WAIT_ACK) && !bus.store_finish &&
                   (ack_cnt_q == AckW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ack_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      if ((state_q == WAIT_ACK) && !bus.store_finish && !timeout) begin
        ack_cnt_q <= ack_cnt_q + 1'b1;
      end else begin
        ack_cnt_q <= '0;
      end
      if (timeout) error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    addr_d    = '0;
    pix_d     = pix_q;
    store_d   = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        if (!fifo_empty) begin
          store_d = 1'b1;
          pix_d   = fifo_rdata;
          if (pix_cnt_q == PF_CNT_W'(PIXELS - 1)) begin
            pix_cnt_d = '0;
            state_d   = WAIT_ACK;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (bus.store_finish) state_d = READY;
        else if (timeout)     state_d = IDLE;
      end
      READY: begin
        if (run) begin
          state_d = SWEEP;
          addr_d  = PF_ADDR_W'(PIXELS);
          start_d = 1'b1;
        end
      end
      SWEEP: begin
        start_d = 1'b1;
        // Address bottoms out at 1; the following cycle drains the last feature.
        if (addr_q > PF_ADDR_W'(1)) begin
          addr_d = addr_q - 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      pix_q     <= '0;
      store_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      addr_q    <= addr_d;
      pix_q     <= pix_d;
      store_q   <= store_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

  assign bus.store       = store_q;
  assign bus.image_pixel = pix_q;
  assign bus.address     = addr_q;
  assign bus.start       = start_q;
  assign bus.feat_valid  = start_q && bus.ready_in;
  assign busy            = (state_q != IDLE);
  assign frame_done      = done_q;

endmodule
